// File: rtl/usb_ep_pkg.sv
// Shared definitions for the banked USB endpoint: status/command bit
// positions of the endpoint control register and handshake codes.
package usb_ep_pkg;

    localparam int ST_BANK   = 5;
    localparam int ST_TOGGLE = 4;
    localparam int ST_STALL  = 3;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 0;

    localparam int CMD_COMMIT = 0;
    localparam int CMD_STALL  = 3;
    localparam int CMD_CLR1   = 4;
    localparam int CMD_CLR0   = 5;

    typedef enum logic [1:0] {
        hs_ack,
        hs_none,
        hs_nak,
        hs_stall
    } usb_hs_e;

endpackage

// File: rtl/usb_idle_timer.sv
// Idle-cycle counter: expires after TIMEOUT consecutive enabled cycles.
// TIMEOUT=0 disables expiry entirely.
module usb_idle_timer #(
    parameter int TIMEOUT = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/usb_ep_in_streamer.sv
// Streams bytes into the free bank of a banked IN endpoint and commits the
// bank on full packet, end of transfer, or idle timeout.
module usb_ep_in_streamer
    import usb_ep_pkg::*;
#(
    parameter int MAX_PKT          = 64,
    parameter int TIMEOUT          = 0,
    parameter bit ZLP_ON_FULL_LAST = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    output logic [6:0]  mem_addr_o,
    output logic [7:0]  mem_wr_data_o,
    output logic        mem_wr_en_o,
    output logic        ctrl_dir_in_o,
    input  logic [15:0] ctrl_rd_data_i,
    output logic [15:0] ctrl_wr_data_o,
    output logic [1:0]  ctrl_wr_en_o,
    output logic        busy_o,
    output logic [15:0] pkt_count_o
);

    typedef enum logic [1:0] {
        WAIT_BANK,
        FILL,
        SET_CNT,
        COMMIT
    } state_e;

    localparam logic [6:0] MAX_OFF = 7'(MAX_PKT);

    state_e      state_q;
    logic [6:0]  offset_q;
    logic        zlp_pend_q;
    logic        last_q;
    logic [15:0] pkt_count_q;

    logic accept;
    logic tmr_clr, tmr_en, tmr_expire;
    logic bank, ep_busy, ep_stall;
    logic unused_status;

    assign bank     = ctrl_rd_data_i[ST_BANK];
    assign ep_busy  = ctrl_rd_data_i[ST_BUSY];
    assign ep_stall = ctrl_rd_data_i[ST_STALL];
    assign unused_status = ^{ctrl_rd_data_i[15:6], ctrl_rd_data_i[ST_TOGGLE],
                             ctrl_rd_data_i[2], ctrl_rd_data_i[ST_EMPTY]};

    assign s_ready_o = (state_q == FILL) && (offset_q < MAX_OFF);
    assign accept    = s_valid_i && s_ready_o;

    assign mem_wr_en_o   = accept;
    assign mem_wr_data_o = s_data_i;
    assign mem_addr_o    = (state_q == FILL) ? {bank, offset_q[5:0]} : 7'd0;
    assign ctrl_dir_in_o = 1'b1;
    assign busy_o        = !((state_q == WAIT_BANK) && !zlp_pend_q);
    assign pkt_count_o   = pkt_count_q;

    always_comb begin
        ctrl_wr_en_o   = 2'b00;
        ctrl_wr_data_o = 16'h0000;
        case (state_q)
            SET_CNT: begin
                ctrl_wr_en_o   = 2'b10;
                ctrl_wr_data_o = {1'b0, offset_q, 8'h00};
            end
            COMMIT: begin
                ctrl_wr_en_o   = 2'b01;
                ctrl_wr_data_o = 16'b1 << CMD_COMMIT;
            end
            default: ;
        endcase
    end

    // Idle time only matters once a partial packet is sitting in the bank.
    assign tmr_clr = accept || (state_q != FILL);
    assign tmr_en  = (state_q == FILL) && (offset_q != 7'd0) && !accept;

    usb_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= WAIT_BANK;
            offset_q    <= 7'd0;
            zlp_pend_q  <= 1'b0;
            last_q      <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            case (state_q)
                WAIT_BANK: begin
                    if (en_i && !ep_busy && !ep_stall)
                        state_q <= zlp_pend_q ? SET_CNT : FILL;
                end
                FILL: begin
                    if (accept) begin
                        offset_q <= offset_q + 7'd1;
                        last_q   <= s_last_i;
                        if ((offset_q + 7'd1 == MAX_OFF) || s_last_i)
                            state_q <= SET_CNT;
                    end else if (tmr_expire) begin
                        state_q <= SET_CNT;
                    end
                end
                SET_CNT: state_q <= COMMIT;
                COMMIT: begin
                    // A full packet closing the transfer needs a trailing ZLP;
                    // the ZLP's own commit sees last_q=0 and clears the flag.
                    zlp_pend_q  <= ZLP_ON_FULL_LAST && last_q && (offset_q == MAX_OFF);
                    last_q      <= 1'b0;
                    offset_q    <= 7'd0;
                    pkt_count_q <= pkt_count_q + 16'd1;
                    state_q     <= WAIT_BANK;
                end
                default: state_q <= WAIT_BANK;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_ep_in_streamer.sv
// Bench: two streamer instances (ZLP on / ZLP off) each driving a small
// banked-endpoint model; expected packets are derived from stream lengths.
module tb_usb_ep_in_streamer;

    localparam int MAXP = 8;
    localparam int TO_A = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en       [2];
    logic [7:0]  s_data   [2];
    logic        s_valid  [2];
    logic        s_last   [2];
    logic        s_ready  [2];
    logic [6:0]  mem_addr [2];
    logic [7:0]  mem_wd   [2];
    logic        mem_we   [2];
    logic        dir_in   [2];
    logic [15:0] rd       [2];
    logic [15:0] wd       [2];
    logic [1:0]  wen      [2];
    logic        busy     [2];
    logic [15:0] pkt      [2];

    usb_ep_in_streamer #(.MAX_PKT(MAXP), .TIMEOUT(TO_A), .ZLP_ON_FULL_LAST(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en[0]), .s_data_i(s_data[0]), .s_valid_i(s_valid[0]),
        .s_last_i(s_last[0]), .s_ready_o(s_ready[0]), .mem_addr_o(mem_addr[0]),
        .mem_wr_data_o(mem_wd[0]), .mem_wr_en_o(mem_we[0]), .ctrl_dir_in_o(dir_in[0]),
        .ctrl_rd_data_i(rd[0]), .ctrl_wr_data_o(wd[0]), .ctrl_wr_en_o(wen[0]),
        .busy_o(busy[0]), .pkt_count_o(pkt[0]));

    usb_ep_in_streamer #(.MAX_PKT(MAXP), .TIMEOUT(0), .ZLP_ON_FULL_LAST(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en[1]), .s_data_i(s_data[1]), .s_valid_i(s_valid[1]),
        .s_last_i(s_last[1]), .s_ready_o(s_ready[1]), .mem_addr_o(mem_addr[1]),
        .mem_wr_data_o(mem_wd[1]), .mem_wr_en_o(mem_we[1]), .ctrl_dir_in_o(dir_in[1]),
        .ctrl_rd_data_i(rd[1]), .ctrl_wr_data_o(wd[1]), .ctrl_wr_en_o(wen[1]),
        .busy_o(busy[1]), .pkt_count_o(pkt[1]));

    // Endpoint model: two buffer banks, count register, bank pointer, stall
    // and a bank-busy bit the bench can hold after a commit.
    logic [7:0] buff      [2][128];
    logic       bank_m    [2] = '{1'b0, 1'b0};
    logic       stall     [2] = '{1'b0, 1'b0};
    int         busy_cnt  [2] = '{0, 0};
    bit         hold_arm  [2] = '{1'b0, 1'b0};
    bit         hold_used [2] = '{1'b0, 1'b0};
    logic [7:0] cnt_reg   [2] = '{8'd0, 8'd0};
    int         nwr       [2] = '{0, 0};
    int         rdy_busy  [2] = '{0, 0};
    int         bad_wr    [2] = '{0, 0};

    int         a_cnt[$];
    bit         a_bank[$];
    logic [7:0] a_dat[$];
    int         b_cnt[$];
    int         exp_cnt[$];
    logic [7:0] exp_dat[$];

    assign rd[0] = {cnt_reg[0], 2'b00, bank_m[0], 1'b0, stall[0], 2'b00, busy_cnt[0] != 0};
    assign rd[1] = {cnt_reg[1], 2'b00, bank_m[1], 1'b0, stall[1], 2'b00, busy_cnt[1] != 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_we[i]) buff[i][mem_addr[i]] <= mem_wd[i];
            if (rd[i][0] && s_ready[i]) rdy_busy[i] <= rdy_busy[i] + 1;
            if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
            if (wen[i] != 2'b00) nwr[i] <= nwr[i] + 1;
            if ((wen[i] == 2'b10 && (wd[i][15] || wd[i][7:0] != 8'h00)) ||
                (wen[i] == 2'b01 && wd[i] != 16'h0001) || wen[i] == 2'b11)
                bad_wr[i] <= bad_wr[i] + 1;
            if (wen[i][1]) cnt_reg[i] <= wd[i][15:8];
            if (wen[i][0] && wd[i][0]) begin
                bank_m[i] <= ~bank_m[i];
                if (hold_arm[i] && !hold_used[i]) begin
                    busy_cnt[i]  <= 50;
                    hold_used[i] <= 1'b1;
                end
                if (i == 0) begin
                    a_cnt.push_back(int'(cnt_reg[0]));
                    a_bank.push_back(bank_m[0]);
                    for (int k = 0; k < int'(cnt_reg[0]); k++)
                        a_dat.push_back(buff[0][{bank_m[0], 6'(k)}]);
                end else begin
                    b_cnt.push_back(int'(cnt_reg[1]));
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference packetisation: full MAXP chunks, remainder, ZLP if none left.
    task automatic exp_stream(input int n, input bit zlp);
        for (int k = 0; k < n / MAXP; k++) exp_cnt.push_back(MAXP);
        if (n % MAXP != 0) exp_cnt.push_back(n % MAXP);
        else if (zlp) exp_cnt.push_back(0);
    endtask

    // Called and returns at posedge+1; s_ready sampled at the negedge.
    task automatic send(input int i, input logic [7:0] d, input bit last, input int gap);
        bit ok, hs;
        s_valid[i] = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid[i] = 1'b1; s_data[i] = d; s_last[i] = last;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk); hs = s_ready[i];
            @(posedge clk); #1;
            if (hs) begin ok = 1'b1; break; end
        end
        s_valid[i] = 1'b0; s_last[i] = 1'b0;
        chk("accept", ok, 1);
    endtask

    task automatic stream(input int i, input int n, input int gapmax, input bit last_end, input bit rnd);
        logic [7:0] d;
        int gap;
        for (int k = 0; k < n; k++) begin
            d = rnd ? 8'($urandom) : 8'(k);
            gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            if (i == 0) exp_dat.push_back(d);
            send(i, d, last_end && (k == n - 1), gap);
        end
    endtask

    task automatic wait_commits(input int i, input int n);
        int got;
        got = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            got = (i == 0) ? a_cnt.size() : b_cnt.size();
            if (got >= n) break;
        end
        chk("commit_wait", got >= n, 1);
        @(posedge clk); #1;
    endtask

    task automatic cmp_a(input string tag);
        int mis;
        chk({tag, "_npkt"}, a_cnt.size(), exp_cnt.size());
        mis = 0;
        for (int k = 0; k < a_cnt.size() && k < exp_cnt.size(); k++)
            if (a_cnt[k] != exp_cnt[k]) mis++;
        chk({tag, "_cnt_mis"}, mis, 0);
        chk({tag, "_nbytes"}, a_dat.size(), exp_dat.size());
        mis = 0;
        for (int k = 0; k < a_dat.size() && k < exp_dat.size(); k++)
            if (a_dat[k] !== exp_dat[k]) mis++;
        chk({tag, "_data_mis"}, mis, 0);
        a_cnt.delete(); a_bank.delete(); a_dat.delete();
        exp_cnt.delete(); exp_dat.delete();
    endtask

    initial begin
        int n0, viol, k, cw, n;
        bit hs, ok;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; s_data[i] = 8'h00; s_valid[i] = 1'b0; s_last[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_mem_we", mem_we[0], 0);
        chk("rst_ctrl_wen", wen[0], 0);
        chk("rst_ctrl_wd", wd[0], 0);
        chk("rst_mem_addr", mem_addr[0], 0);
        chk("rst_pkt", pkt[0], 0);
        chk("rst_b_busy", busy[1], 0);
        @(posedge clk); #1; rst = 1'b0;

        repeat (5) begin @(negedge clk); chk("en_low_ready", s_ready[0], 0); end
        @(posedge clk); #1; en[0] = 1'b1; en[1] = 1'b1;

        // 20 sequential bytes -> 8, 8, 4 across alternating banks
        exp_stream(20, 1'b1);
        stream(0, 20, 0, 1'b1, 1'b0);
        wait_commits(0, 3);
        chk("seq_bank0", a_bank[0], 0);
        chk("seq_bank1", a_bank[1], 1);
        chk("seq_bank2", a_bank[2], 0);
        chk("seq_pkt", pkt[0], 3);
        cmp_a("seq");

        // full last packet: ZLP on A, none on B
        exp_stream(16, 1'b1);
        stream(0, 16, 0, 1'b1, 1'b1);
        wait_commits(0, 3);
        chk("zlp_pkt", pkt[0], 6);
        cmp_a("zlp");
        stream(1, 16, 0, 1'b1, 1'b1);
        wait_commits(1, 2);
        repeat (30) @(posedge clk); #1;
        chk("nozlp_npkt", b_cnt.size(), 2);
        chk("nozlp_c0", b_cnt[0], 8);
        chk("nozlp_c1", b_cnt[1], 8);
        chk("nozlp_pkt", pkt[1], 2);

        // random streams with gaps; bank held busy 50 cycles after first commit
        hold_arm[0] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(30, 1));
            exp_stream(n, 1'b1);
            stream(0, n, 3, 1'b1, 1'b1);
        end
        wait_commits(0, exp_cnt.size());
        repeat (5) @(posedge clk); #1;
        cmp_a("rand");
        chk("ready_while_bank_busy", rdy_busy[0], 0);

        // idle timeout on a 3-byte partial packet
        exp_cnt.push_back(3);
        stream(0, 3, 0, 1'b0, 1'b1);
        k = -1; cw = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (wen[0] == 2'b10) begin k = t; cw = int'(wd[0][14:8]); break; end
            @(posedge clk);
        end
        @(posedge clk); #1;
        chk("timeout_idle_cycles", k, TO_A);
        chk("timeout_set_cnt", cw, 3);
        wait_commits(0, 1);
        cmp_a("timeout");

        // stall raised mid-FILL still commits; stall in WAIT_BANK blocks
        exp_cnt.push_back(8); exp_cnt.push_back(1);
        stream(0, 4, 0, 1'b0, 1'b1);
        stall[0] = 1'b1;
        stream(0, 4, 0, 1'b0, 1'b1);
        wait_commits(0, 1);
        @(negedge clk);
        chk("stall_idle_busy", busy[0], 0);
        @(posedge clk); #1;
        n0 = nwr[0];
        s_valid[0] = 1'b1; s_data[0] = 8'($urandom); s_last[0] = 1'b1;
        exp_dat.push_back(s_data[0]);
        viol = 0;
        repeat (30) begin
            @(negedge clk); if (s_ready[0] || mem_we[0]) viol++;
            @(posedge clk); #1;
        end
        chk("stall_blocked", viol, 0);
        chk("stall_no_ctrl_wr", nwr[0] - n0, 0);
        stall[0] = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk); hs = s_ready[0];
            @(posedge clk); #1;
            if (hs) begin ok = 1'b1; break; end
        end
        s_valid[0] = 1'b0; s_last[0] = 1'b0;
        chk("stall_release_accept", ok, 1);
        wait_commits(0, 2);
        cmp_a("stall");

        // reset mid-packet abandons the partial bank silently
        stream(0, 5, 0, 1'b0, 1'b1);
        exp_dat.delete();
        n0 = nwr[0];
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_s_ready", s_ready[0], 0);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_ctrl_wen", wen[0], 0);
        chk("mid_rst_ctrl_wd", wd[0], 0);
        chk("mid_rst_mem_addr", mem_addr[0], 0);
        chk("mid_rst_mem_we", mem_we[0], 0);
        chk("mid_rst_pkt", pkt[0], 0);
        @(posedge clk); #1; rst = 1'b0;
        chk("mid_rst_no_ctrl_wr", nwr[0] - n0, 0);
        exp_cnt.push_back(6);
        stream(0, 6, 1, 1'b1, 1'b1);
        wait_commits(0, 1);
        chk("post_rst_pkt", pkt[0], 1);
        cmp_a("post_rst");

        chk("ctrl_wr_format_a", bad_wr[0], 0);
        chk("ctrl_wr_format_b", bad_wr[1], 0);
        chk("dir_in_a", dir_in[0], 1);
        chk("dir_in_b", dir_in[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
